// File: rtl/mem_rsp_pkg.sv
// ============================================================================
// Module      : mem_rsp_pkg
// Description : Shared opcodes, state encoding and line width for the
//               L2 backing-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_rsp_pkg;

   localparam logic [3:0] MEM_LINE_LD = 4'd4;
   localparam logic [3:0] MEM_LINE_ST = 4'd7;
   localparam int         LINE_BITS   = 512;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      RESP  = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/line_ram.sv
// ============================================================================
// Module      : line_ram
// Description : Single-port 2^LG_LINES x 512-bit line store, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_ram
   import mem_rsp_pkg::*;
#(
   parameter int LG_LINES = 14
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 we,
   input  logic [LG_LINES-1:0]  addr,
   input  logic [LINE_BITS-1:0] wdata,
   output logic [LINE_BITS-1:0] rdata
);

   logic [LINE_BITS-1:0] r_mem [0:(1<<LG_LINES)-1];

   // Contents deliberately have no reset so they survive a core reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            r_mem[addr] <= wdata;
         end else begin
            rdata <= r_mem[addr];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/l2_mem_responder.sv
// ============================================================================
// Module      : l2_mem_responder
// Description : Line load/store responder replacing DRAM behind the L2, with
//               a fixed request-to-response latency. Optional statistics
//               counters are enabled with macro MEM_RSP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_mem_responder
   import mem_rsp_pkg::*;
#(
   parameter int M_WIDTH  = 32,
   parameter int LG_LINES = 14,
   parameter int LATENCY  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_req_valid,
   input  logic [M_WIDTH-1:0]   mem_req_addr,
   input  logic [LINE_BITS-1:0] mem_req_store_data,
   input  logic [3:0]           mem_req_opcode,
   output logic                 mem_rsp_valid,
   output logic [LINE_BITS-1:0] mem_rsp_load_data,
   output logic                 busy,
   output logic                 err
`ifdef MEM_RSP_STATS_EN
   ,
   output logic [63:0]          stat_loads,
   output logic [63:0]          stat_stores,
   output logic [63:0]          stat_busy_cycles
`endif
);

   localparam logic [7:0] c_lat_m1 = 8'(LATENCY - 1);
   localparam int         c_hi_w   = M_WIDTH - 6;

   state_t               r_state;
   state_t               w_next;
   logic [7:0]           r_cnt;
   logic [c_hi_w-1:0]    r_line_addr;
   logic [3:0]           r_opcode;
   logic [LINE_BITS-1:0] r_wdata;
   logic [LINE_BITS-1:0] r_load_data;
   logic                 r_err;
   logic [LINE_BITS-1:0] w_ram_rdata;
   logic [LINE_BITS-1:0] w_rsp_data;
   logic                 w_in_range;
   logic                 w_is_ld;
   logic                 w_is_st;
   logic                 w_ram_rd;
   logic                 w_ram_wr;
   logic [5:0]           w_unused_lsb;

   assign w_unused_lsb = mem_req_addr[5:0];
   assign w_is_ld      = (r_opcode == MEM_LINE_LD);
   assign w_is_st      = (r_opcode == MEM_LINE_ST);

   generate
      if (c_hi_w > LG_LINES) begin : g_range_chk
         assign w_in_range = (r_line_addr[c_hi_w-1:LG_LINES] == '0);
      end else begin : g_range_full
         assign w_in_range = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The RAM read is launched one cycle early so registered data meets RESP.
   always_comb begin
      w_next   = r_state;
      w_ram_rd = 1'b0;
      w_ram_wr = 1'b0;
      case (r_state)
         IDLE: begin
            if (mem_req_valid) begin
               w_next = WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == 8'd1) begin
               w_ram_rd = w_is_ld & w_in_range;
               w_next   = RESP;
            end
         end
         RESP: begin
            w_ram_wr = w_is_st & w_in_range;
            w_next   = DRAIN;
         end
         DRAIN: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= 8'd0;
         r_line_addr <= '0;
         r_opcode    <= 4'd0;
         r_wdata     <= '0;
         r_load_data <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (mem_req_valid) begin
                  r_line_addr <= mem_req_addr[M_WIDTH-1:6];
                  r_opcode    <= mem_req_opcode;
                  r_wdata     <= mem_req_store_data;
                  r_cnt       <= c_lat_m1;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 8'd1;
            end
            RESP: begin
               r_load_data <= w_rsp_data;
               if (!(w_is_ld | w_is_st) || !w_in_range) begin
                  r_err <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign w_rsp_data        = (w_is_ld & w_in_range) ? w_ram_rdata : '0;
   assign mem_rsp_valid     = (r_state == RESP);
   assign mem_rsp_load_data = (r_state == RESP) ? w_rsp_data : r_load_data;
   assign busy              = (r_state != IDLE);
   assign err               = r_err;

   line_ram #(
      .LG_LINES (LG_LINES)
   ) u_ram (
      .clk   (clk),
      .en    (w_ram_rd | w_ram_wr),
      .we    (w_ram_wr),
      .addr  (r_line_addr[LG_LINES-1:0]),
      .wdata (r_wdata),
      .rdata (w_ram_rdata)
   );

`ifdef MEM_RSP_STATS_EN
   logic [63:0] r_stat_loads;
   logic [63:0] r_stat_stores;
   logic [63:0] r_stat_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_loads  <= 64'd0;
         r_stat_stores <= 64'd0;
         r_stat_busy   <= 64'd0;
      end else begin
         if ((r_state == RESP) && w_is_ld) begin
            r_stat_loads <= r_stat_loads + 64'd1;
         end
         if ((r_state == RESP) && w_is_st) begin
            r_stat_stores <= r_stat_stores + 64'd1;
         end
         if (busy) begin
            r_stat_busy <= r_stat_busy + 64'd1;
         end
      end
   end

   assign stat_loads       = r_stat_loads;
   assign stat_stores      = r_stat_stores;
   assign stat_busy_cycles = r_stat_busy;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_responder.sv
// ============================================================================
// Module      : tb_l2_mem_responder
// Description : Directed vector bench for l2_mem_responder at LATENCY 4 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_mem_responder;
   import mem_rsp_pkg::*;

   localparam logic [511:0] DB = {16{32'hdeadbeef}};
   localparam logic [511:0] L0 = {16{32'h11111111}};
   localparam logic [511:0] L8 = {16{32'h80808080}};
   localparam logic [511:0] A5 = {16{32'ha5a5a5a5}};
   localparam logic [511:0] FF = {16{32'hffffffff}};
   localparam logic [511:0] CF = {16{32'hcafef00d}};
   localparam logic [511:0] NW = {16{32'h12345678}};
   localparam logic [511:0] BD = {16{32'hbad0bad0}};
   localparam logic [511:0] Z  = '0;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         a_valid = 1'b0, b_valid = 1'b0;
   logic [31:0]  a_addr = '0, b_addr = '0;
   logic [511:0] a_sd = '0, b_sd = '0;
   logic [3:0]   a_op = '0, b_op = '0;
   logic         a_rv, b_rv, a_busy, b_busy, a_err, b_err;
   logic [511:0] a_rd, b_rd;
`ifdef MEM_RSP_STATS_EN
   logic [63:0]  a_stl, a_sts, a_stb, b_stl, b_sts, b_stb;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   l2_mem_responder #(.M_WIDTH(32), .LG_LINES(14), .LATENCY(4)) u_dut (
      .clk                (clk),
      .reset              (reset),
      .mem_req_valid      (a_valid),
      .mem_req_addr       (a_addr),
      .mem_req_store_data (a_sd),
      .mem_req_opcode     (a_op),
      .mem_rsp_valid      (a_rv),
      .mem_rsp_load_data  (a_rd),
      .busy               (a_busy),
      .err                (a_err)
`ifdef MEM_RSP_STATS_EN
      ,
      .stat_loads         (a_stl),
      .stat_stores        (a_sts),
      .stat_busy_cycles   (a_stb)
`endif
   );

   l2_mem_responder #(.M_WIDTH(32), .LG_LINES(14), .LATENCY(2)) u_dut2 (
      .clk                (clk),
      .reset              (reset),
      .mem_req_valid      (b_valid),
      .mem_req_addr       (b_addr),
      .mem_req_store_data (b_sd),
      .mem_req_opcode     (b_op),
      .mem_rsp_valid      (b_rv),
      .mem_rsp_load_data  (b_rd),
      .busy               (b_busy),
      .err                (b_err)
`ifdef MEM_RSP_STATS_EN
      ,
      .stat_loads         (b_stl),
      .stat_stores        (b_sts),
      .stat_busy_cycles   (b_stb)
`endif
   );

   typedef struct {
      bit           rst;
      logic [3:0]   op;
      logic [31:0]  addr;
      logic [511:0] wd;
      logic [511:0] ed;
      logic         ee;
   } vec_t;

   vec_t tv [12];

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic [3:0] op,
                        input logic [31:0] ad, input logic [511:0] d);
      if (sel) begin
         b_valid = v; b_op = op; b_addr = ad; b_sd = d;
      end else begin
         a_valid = v; a_op = op; a_addr = ad; a_sd = d;
      end
   endtask

   // Entered and left at a negedge with the DUT idle.
   task automatic txn(input bit sel, input logic [3:0] op, input logic [31:0] addr,
                      input logic [511:0] wd, input int exp_lat, input logic [511:0] exp_d,
                      input logic exp_e, input string nm);
      int           n;
      bit           got;
      logic [511:0] d;
      n = 0; got = 0; d = '0;
      drive(sel, 1'b1, op, addr, wd);
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk({nm, "_busy"}, sel ? b_busy : a_busy, 1'b1);
            drive(sel, 1'b1, MEM_LINE_ST, 32'h0, BD);
         end
         if (sel ? b_rv : a_rv) begin
            got = 1;
            d   = sel ? b_rd : a_rd;
         end
      end
      chk({nm, "_lat"}, 512'(n), 512'(exp_lat));
      chk({nm, "_data"}, d, exp_d);
      @(negedge clk);
      chk({nm, "_pulse"}, sel ? b_rv : a_rv, 1'b0);
      chk({nm, "_hold"}, sel ? b_rd : a_rd, exp_d);
      chk({nm, "_err"}, sel ? b_err : a_err, exp_e);
      drive(sel, 1'b0, 4'd0, 32'h0, Z);
      @(negedge clk);
      chk({nm, "_idle"}, sel ? b_busy : a_busy, 1'b0);
   endtask

   initial begin
      logic [11:0]  mask;
      logic [511:0] d2;
      int           cnt;

      tv[0]  = '{0, MEM_LINE_ST, 32'h0000_0040, DB, Z,  1'b0};
      tv[1]  = '{0, MEM_LINE_LD, 32'h0000_0040, Z,  DB, 1'b0};
      tv[2]  = '{0, MEM_LINE_ST, 32'h0000_0000, L0, Z,  1'b0};
      tv[3]  = '{0, MEM_LINE_ST, 32'h0000_0080, L8, Z,  1'b0};
      tv[4]  = '{0, MEM_LINE_LD, 32'h0000_0000, Z,  L0, 1'b0};
      tv[5]  = '{0, MEM_LINE_LD, 32'h0000_0080, Z,  L8, 1'b0};
      tv[6]  = '{0, MEM_LINE_ST, 32'h4000_0000, A5, Z,  1'b1};
      tv[7]  = '{0, MEM_LINE_LD, 32'h4000_0000, Z,  Z,  1'b1};
      tv[8]  = '{0, MEM_LINE_LD, 32'h0000_0000, Z,  L0, 1'b1};
      tv[9]  = '{1, 4'd9,        32'h0000_0040, FF, Z,  1'b1};
      tv[10] = '{1, MEM_LINE_LD, 32'h0000_0040, Z,  DB, 1'b0};
      tv[11] = '{0, MEM_LINE_LD, 32'h0000_007f, Z,  DB, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_rv",   a_rv,   1'b0);
      chk("rst_data", a_rd,   Z);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_err",  a_err,  1'b0);
      chk("rst_rv2",  b_rv,   1'b0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         if (tv[i].rst) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         txn(1'b0, tv[i].op, tv[i].addr, tv[i].wd, 4, tv[i].ed, tv[i].ee,
             $sformatf("v%0d", i));
      end

      // Valid held high: second acceptance only after DRAIN.
      mask = '0; d2 = '0;
      drive(1'b0, 1'b1, MEM_LINE_LD, 32'h40, Z);
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         mask[n] = a_rv;
         if (n == 10) begin
            d2 = a_rd;
            drive(1'b0, 1'b0, 4'd0, 32'h0, Z);
         end
      end
      chk("hold_mask", mask, 12'h410);
      chk("hold_d2", d2, DB);
      @(negedge clk);
      chk("hold_idle", a_busy, 1'b0);

      // Reset in WAIT of a store abandons it.
      drive(1'b0, 1'b1, MEM_LINE_ST, 32'h80, NW);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 1'b0, 4'd0, 32'h0, Z);
      @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (a_rv) cnt++;
      end
      chk("abort_rv", 512'(cnt), 512'd0);
      chk("abort_busy", a_busy, 1'b0);
`ifdef MEM_RSP_STATS_EN
      chk("abort_stst", a_sts, 64'd0);
`endif
      txn(1'b0, MEM_LINE_LD, 32'h80, Z, 4, L8, 1'b0, "abort_ld");
`ifdef MEM_RSP_STATS_EN
      chk("stat_ld", a_stl, 64'd1);
      chk("stat_busy", a_stb, 64'd5);
`endif

      // LATENCY=2 instance.
      txn(1'b1, MEM_LINE_ST, 32'h1000, CF, 2, Z,  1'b0, "l2_st");
      txn(1'b1, MEM_LINE_LD, 32'h1000, Z,  2, CF, 1'b0, "l2_ld");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
